// File: rtl/seg_display_arbiter.sv
// ---------------------------------------------------------------------------
// seg_display_arbiter
//
// Shares one 2-digit 7-segment PMOD between N_REQ BCD sources. The display
// is granted round-robin. Each owner keeps it for DWELL_CYCLES clocks, or
// less if it lets go early. The owner's two BCD digits are time-multiplexed
// onto the shared segment and digit-select pins.
//
// Request/grant protocol: req[i] is a level request. A source raises it and
// holds it high for as long as it wants the display. grant[i] (registered)
// tells the source it currently owns the display. A source releases the
// display by dropping req[i]. Changes on non-owner requests are ignored
// until the current owner's dwell expires or the owner releases.
//
// Ports
//   clk      system clock, all logic on posedge
//   rst_n    asynchronous active-low reset
//   req      level request per source
//   bcd_in   source i value at [8i+7:8i]; [7:4] tens, [3:0] units
//   grant    one-hot current owner; all-zero when idle
//   owner    binary index of owner; meaningful only while busy=1
//   busy     1 while an owner is granted
//   a..g     segments, active-low (0 = lit)
//   sel      digit select: 1 = units digit, 0 = tens digit
//
// Internal FSM state is held in "state" (IDLE/HOLD) for observation.
// ---------------------------------------------------------------------------
module seg_display_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int REFRESH_BITS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] bcd_in,
  output logic [N_REQ-1:0]   grant,
  output logic [2:0]         owner,
  output logic               busy,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               d,
  output logic               e,
  output logic               f,
  output logic               g,
  output logic               sel
);

  localparam int             DW         = $clog2(DWELL_CYCLES);
  localparam logic [DW-1:0]  DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [2:0]     PTR_RESET  = 3'(N_REQ - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                  state, state_nx;
  logic [DW-1:0]           dwell_cnt, dwell_nx;
  logic [2:0]              last_ptr, last_nx;
  logic [N_REQ-1:0]        grant_nx;
  logic [2:0]              owner_nx;
  logic                    busy_nx;

  logic                    win_found;
  logic [2:0]              win_idx;
  logic [N_REQ-1:0]        win_onehot;
  logic [3:0]              cand;
  logic                    owner_req;
  logic                    rearb;

  logic [REFRESH_BITS-1:0] refresh_cnt;
  logic [7:0]              owner_bcd;
  logic [3:0]              nibble;
  logic [6:0]              seg_lit;   // active-high {a,b,c,d,e,f,g}
  logic [6:0]              seg_q;     // active-low, registered

  // Round-robin search: first set request strictly after last_ptr, wrapping.
  // If only the last owner requests, the search wraps back onto it.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    cand       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = 4'(last_ptr) + 4'(k) + 4'd1;
      if (cand >= 4'(N_REQ)) begin
        cand = cand - 4'(N_REQ);
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!win_found && (cand == 4'(i)) && req[i]) begin
          win_found = 1'b1;
          win_idx   = 3'(i);
        end
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      win_onehot[i] = win_found && (win_idx == 3'(i));
    end
  end

  // Current owner's request and BCD value, selected by the owner register.
  always_comb begin
    owner_req = 1'b0;
    owner_bcd = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner == 3'(i)) begin
        owner_req = req[i];
        owner_bcd = bcd_in[8*i +: 8];
      end
    end
  end

  // FSM next state. IDLE always arbitrates; with no request it simply
  // stays idle. In HOLD, release (owner drops req) and expiry share one
  // path, so a simultaneous drop and expiry behaves as a release.
  always_comb begin
    state_nx = state;
    dwell_nx = dwell_cnt;
    last_nx  = last_ptr;
    grant_nx = grant;
    owner_nx = owner;
    busy_nx  = busy;
    rearb    = 1'b0;

    case (state)
      IDLE:    rearb = 1'b1;
      HOLD:    rearb = !owner_req || (dwell_cnt == DWELL_LAST);
      default: rearb = 1'b1;
    endcase

    if (rearb) begin
      dwell_nx = '0;
      if (win_found) begin
        state_nx = HOLD;
        grant_nx = win_onehot;
        owner_nx = win_idx;
        busy_nx  = 1'b1;
        last_nx  = win_idx;
      end else begin
        state_nx = IDLE;
        grant_nx = '0;
        busy_nx  = 1'b0;
      end
    end else begin
      dwell_nx = dwell_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dwell_cnt <= '0;
      last_ptr  <= PTR_RESET;
      grant     <= '0;
      owner     <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      dwell_cnt <= dwell_nx;
      last_ptr  <= last_nx;
      grant     <= grant_nx;
      owner     <= owner_nx;
      busy      <= busy_nx;
    end
  end

  // Display path. The refresh MSB picks the digit: 0 -> units, 1 -> tens.
  // Nibble and busy are taken from this cycle and registered, so the pins
  // trail the grant by one clock.
  assign nibble = refresh_cnt[REFRESH_BITS-1] ? owner_bcd[7:4] : owner_bcd[3:0];

  always_comb begin
    seg_lit = 7'b0000001;   // dash for 10..15
    case (nibble)
      4'd0:    seg_lit = 7'b1111110;
      4'd1:    seg_lit = 7'b0110000;
      4'd2:    seg_lit = 7'b1101101;
      4'd3:    seg_lit = 7'b1111001;
      4'd4:    seg_lit = 7'b0110011;
      4'd5:    seg_lit = 7'b1011011;
      4'd6:    seg_lit = 7'b1011111;
      4'd7:    seg_lit = 7'b1110000;
      4'd8:    seg_lit = 7'b1111111;
      4'd9:    seg_lit = 7'b1111011;
      default: seg_lit = 7'b0000001;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      seg_q       <= 7'h7f;
      sel         <= 1'b1;
    end else begin
      refresh_cnt <= refresh_cnt + REFRESH_BITS'(1);
      seg_q       <= busy ? ~seg_lit : 7'h7f;
      sel         <= ~refresh_cnt[REFRESH_BITS-1];
    end
  end

  assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// ---------------------------------------------------------------------------
// tb_seg_display_arbiter
//
// Directed bench for seg_display_arbiter with N_REQ=4, DWELL_CYCLES=8,
// REFRESH_BITS=4. A behavioural model tracks owner, time held and the
// refresh phase, and is compared with the DUT on every falling edge.
// Literal expectations along the directed sequence pin the model.
// ---------------------------------------------------------------------------
module tb_seg_display_arbiter;

  localparam int N_REQ  = 4;
  localparam int DWELL  = 8;
  localparam int RBITS  = 4;
  localparam int PERIOD = 1 << RBITS;

  // ---------------- clock / reset ----------------
  logic               clk;
  logic               rst_n;
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] bcd_in;
  logic [N_REQ-1:0]   grant;
  logic [2:0]         owner;
  logic               busy;
  logic               a, b, c, d, e, f, g;
  logic               sel;
  logic [6:0]         seg;

  assign seg = {a, b, c, d, e, f, g};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  seg_display_arbiter #(
    .N_REQ        (N_REQ),
    .DWELL_CYCLES (DWELL),
    .REFRESH_BITS (RBITS)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .bcd_in (bcd_in),
    .grant  (grant),
    .owner  (owner),
    .busy   (busy),
    .a      (a),
    .b      (b),
    .c      (c),
    .d      (d),
    .e      (e),
    .f      (f),
    .g      (g),
    .sel    (sel)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Segment pattern from the list of lit segment letters of each digit.
  function automatic logic [6:0] seg_of(input int n);
    string      lit;
    logic [6:0] mask;
    case (n)
      0:       lit = "abcdef";
      1:       lit = "bc";
      2:       lit = "abdeg";
      3:       lit = "abcdg";
      4:       lit = "bcfg";
      5:       lit = "acdfg";
      6:       lit = "acdefg";
      7:       lit = "abc";
      8:       lit = "abcdefg";
      9:       lit = "abcdfg";
      default: lit = "g";
    endcase
    mask = 7'h7f;
    for (int i = 0; i < lit.len(); i++) mask[6 - (int'(lit[i]) - 97)] = 1'b0;
    return mask;
  endfunction

  // Next owner: first requester after the last owner, wrapping; -1 if none.
  function automatic int pick(input logic [N_REQ-1:0] r, input int last);
    for (int k = 1; k <= N_REQ; k++) begin
      if (r[(last + k) % N_REQ]) return (last + k) % N_REQ;
    end
    return -1;
  endfunction

  int         m_owner;   // -1 when idle
  int         m_held;    // cycles the owner has been visible, 1 on grant
  int         m_last;
  int         m_cyc;     // refresh count
  logic [6:0] m_seg;
  logic       m_sel;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_held  <= 0;
      m_last  <= N_REQ - 1;
      m_cyc   <= 0;
      m_seg   <= 7'h7f;
      m_sel   <= 1'b1;
    end else begin
      if (m_owner >= 0)
        m_seg <= seg_of((m_cyc >= PERIOD / 2) ? int'(bcd_in[8*m_owner+4 +: 4])
                                              : int'(bcd_in[8*m_owner +: 4]));
      else
        m_seg <= 7'h7f;
      m_sel <= (m_cyc < PERIOD / 2);
      m_cyc <= (m_cyc + 1) % PERIOD;
      if (m_owner < 0 || !req[m_owner] || m_held == DWELL) begin
        m_owner <= pick(req, m_last);
        m_held  <= 1;
        if (pick(req, m_last) >= 0) m_last <= pick(req, m_last);
      end else begin
        m_held <= m_held + 1;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("model_busy",  32'(busy),  32'(m_owner >= 0));
      if (m_owner >= 0) check("model_owner", 32'(owner), 32'(m_owner));
      check("model_seg",   32'(seg),   32'(m_seg));
      check("model_sel",   32'(sel),   32'(m_sel));
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [N_REQ-1:0]   r;
    logic [8*N_REQ-1:0] v;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n  = 1'b0;
    req    = '0;
    bcd_in = '0;
    tick(1);
    cmp_en = 1'b1;
    tick(2);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_busy",  32'(busy),  32'd0);
    check("reset_seg",   32'(seg),   32'h7f);
    check("reset_sel",   32'(sel),   32'd1);
    rst_n = 1'b1;
    tick(2);
    check("idle_grant", 32'(grant), 32'd0);

    // req=1010: owner 1 for 8 cycles, then 3 for 8, then back to 1.
    req = 4'b1010;
    tick(1); check("rr_first",  32'(grant), 32'b0010);
             check("rr_owner",  32'(owner), 32'd1);
    tick(7); check("rr_hold1",  32'(grant), 32'b0010);
    tick(1); check("rr_second", 32'(grant), 32'b1000);
    tick(7); check("rr_hold3",  32'(grant), 32'b1000);
    tick(1); check("rr_back",   32'(grant), 32'b0010);
    req = 4'b0000;
    tick(1); check("rr_idle",   32'(busy),  32'd0);
    tick(1);

    // Sole requester keeps the display across expiries.
    req = 4'b0100;
    tick(1);
    for (int i = 0; i < 20; i++) begin
      check("sole_grant", 32'(grant), 32'b0100);
      check("sole_busy",  32'(busy),  32'd1);
      tick(1);
    end
    req = 4'b0000;
    tick(1); check("sole_idle", 32'(busy), 32'd0);

    // Early release at dwell count 3 hands over at once; dwell restarts.
    req = 4'b0001;
    tick(1); check("rel_own0",  32'(grant), 32'b0001);
    req = 4'b1001;
    tick(3); check("rel_cnt3",  32'(grant), 32'b0001);
    req = 4'b1000;
    tick(1); check("rel_to3",   32'(grant), 32'b1000);
    req = 4'b1001;
    tick(7); check("rel_full",  32'(grant), 32'b1000);
    tick(1); check("rel_back0", 32'(grant), 32'b0001);

    // Reset mid-HOLD, asynchronous.
    #3 rst_n = 1'b0;
    #1;
    check("arst_grant", 32'(grant), 32'd0);
    check("arst_busy",  32'(busy),  32'd0);
    check("arst_seg",   32'(seg),   32'h7f);
    check("arst_sel",   32'(sel),   32'd1);
    req    = 4'b1111;
    bcd_in = {4{8'h27}};
    tick(3);
    rst_n = 1'b1;

    // Digit multiplex: units 7 for the first half period, tens 2 after.
    tick(1);
    check("mux_first_grant", 32'(grant), 32'b0001);
    check("mux_latency_seg", 32'(seg),   32'h7f);
    for (int j = 2; j <= 8; j++) begin
      tick(1);
      check("mux_units_sel", 32'(sel), 32'd1);
      check("mux_units_seg", 32'(seg), 32'b0001111);
    end
    for (int j = 9; j <= 16; j++) begin
      tick(1);
      check("mux_tens_sel", 32'(sel), 32'd0);
      check("mux_tens_seg", 32'(seg), 32'b0010010);
    end

    // Owner 2 with C3: units 3, tens dash, then blank two cycles after req=0.
    req = 4'b0100;
    bcd_in[23:16] = 8'hC3;
    tick(1);
    check("c3_grant",   32'(grant), 32'b0100);
    check("c3_old_seg", 32'(seg),   32'b0001111);
    for (int j = 18; j <= 24; j++) begin
      tick(1);
      check("c3_units", 32'(seg), 32'b0000110);
    end
    for (int j = 25; j <= 32; j++) begin
      tick(1);
      check("c3_dash", 32'(seg), 32'b1111110);
      check("c3_sel",  32'(sel), 32'd0);
    end
    req = 4'b0000;
    tick(1);
    check("off_busy",  32'(busy), 32'd0);
    check("off_seg1",  32'(seg),  32'b0000110);
    tick(1);
    check("off_blank", 32'(seg),  32'h7f);
    check("off_sel",   32'(sel),  32'd1);

    // Mixed request patterns with live BCD changes; the model checks these.
    vecs[0] = '{4'b1111, 32'h0123_4567};
    vecs[1] = '{4'b1111, 32'h89AB_CDEF};
    vecs[2] = '{4'b0110, 32'h5566_7788};
    vecs[3] = '{4'b1001, 32'h9900_4411};
    vecs[4] = '{4'b0000, 32'h1234_5678};
    vecs[5] = '{4'b0010, 32'h1234_5678};
    vecs[6] = '{4'b1010, 32'h9A8B_7C6D};
    vecs[7] = '{4'b1101, 32'h1029_3847};
    for (int v = 0; v < 8; v++) begin
      req    = vecs[v].r;
      bcd_in = vecs[v].v;
      tick(6);
    end
    req = 4'b0000;
    tick(3);
    check("end_idle", 32'(busy), 32'd0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
